// File: rtl/aes_pkg.sv
// Shared AES-128 encryption constants, round-constant update and FSM encoding.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package aes_pkg;

  localparam int          AES_NR        = 10;
  localparam logic [7:0]  RCON_INIT     = 8'h01;
  localparam logic [7:0]  AES_RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 on-the-fly key schedule: current round key in, next round key out.
// Latency: combinational; the SubWord lookup is a round trip through an external S-box word.
// Backpressure: none; purely combinational.
//
// Ports:
//   key_i        current round key, word j at [32j+31:32j], row 0 in the low byte of each word
//   rcon_i       round constant applied to this step
//   sw_word_out  RotWord(w3), sent to the external S-box
//   sw_word_in   SubWord result returned by the external S-box
//   rnd_key_o    next round key {n3, n2, n1, n0}
module aes_key_step (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic [31:0]  sw_word_in,
  output logic [31:0]  sw_word_out,
  output logic [127:0] rnd_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[31:0];
  assign w1 = key_i[63:32];
  assign w2 = key_i[95:64];
  assign w3 = key_i[127:96];

  // Row 0 lives in the low byte, so rotating rows up by one is a right rotate by 8 bits.
  assign sw_word_out = {w3[7:0], w3[31:8]};

  assign n0 = w0 ^ sw_word_in ^ {24'h0, rcon_i};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rnd_key_o = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, then one external round per cycle.
// Latency: accept in cycle 0, rounds in cycles 1..10, out_valid from cycle 11; one block per 11 cycles.
// Backpressure: result held in DONE until out_ready; a new block can be accepted in the draining cycle.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_plaintext/in_key   input handshake, byte i at [8i+7:8i]
//   abort                               synchronous cancel of the current operation
//   out_valid/out_ready/out_ciphertext  result handshake
//   busy, round_idx                     status: in ROUND, current round 1..10 (0 otherwise)
//   rnd_state/rnd_key/rnd_final/rnd_next_state   interface to the external round datapath
//   sw_word_out/sw_word_in              interface to the external S-box word
module aes_round_controller #(
  parameter int         NUM_ROUNDS = aes_pkg::AES_NR,
  parameter logic [7:0] RCON_INIT  = aes_pkg::RCON_INIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_plaintext,
  input  logic [127:0] in_key,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_final,
  input  logic [127:0] rnd_next_state,
  output logic [31:0]  sw_word_out,
  input  logic [31:0]  sw_word_in
);

  import aes_pkg::*;

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_round_controller supports only NUM_ROUNDS == 10 (AES-128)");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_state_e   state_q, state_d;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [127:0] ct_q;

  logic accept;
  logic last_rnd;

  assign accept   = in_valid && in_ready;
  assign last_rnd = (round_q == LAST_RND);

  aes_key_step u_key_step (
    .key_i       (key_q),
    .rcon_i      (rcon_q),
    .sw_word_in  (sw_word_in),
    .sw_word_out (sw_word_out),
    .rnd_key_o   (rnd_key)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Abort wins over both the output handshake and acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (abort)         state_d = ST_IDLE;
        else if (last_rnd) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort)          state_d = ST_IDLE;
        else if (accept)    state_d = ST_ROUND;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. in_ready drops under abort so a handshake never completes
  // in a cycle where the block would be thrown away.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE:  in_ready  = !abort;
      ST_ROUND: busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !abort;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
    end else if (abort && (state_q != ST_IDLE)) begin
      round_q <= '0;
    end else if (accept) begin
      st_q    <= in_plaintext ^ in_key;
      key_q   <= in_key;
      rcon_q  <= RCON_INIT;
      round_q <= 4'd1;
    end else if (state_q == ST_ROUND) begin
      st_q   <= rnd_next_state;
      key_q  <= rnd_key;
      rcon_q <= xtime(rcon_q);
      if (last_rnd) begin
        ct_q    <= rnd_next_state;
        round_q <= '0;
      end else begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  assign out_ciphertext = ct_q;
  assign round_idx      = round_q;
  assign rnd_state      = st_q;
  assign rnd_final      = busy && last_rnd;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: provides the round datapath and S-box, scoreboards results.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while a result is pending.
module tb_aes_round_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic [127:0] in_key;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;
  logic         busy;
  logic [3:0]   round_idx;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic [127:0] rnd_next_state;
  logic [31:0]  sw_word_out;
  logic [31:0]  sw_word_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic ov_prev = 1'b0;
  logic [127:0] sb[$];

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  aes_round_controller dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_plaintext   (in_plaintext),
    .in_key         (in_key),
    .abort          (abort),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ciphertext (out_ciphertext),
    .busy           (busy),
    .round_idx      (round_idx),
    .rnd_state      (rnd_state),
    .rnd_key        (rnd_key),
    .rnd_final      (rnd_final),
    .rnd_next_state (rnd_next_state),
    .sw_word_out    (sw_word_out),
    .sw_word_in     (sw_word_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference pieces (external datapath + S-box) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(st[8*i +: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r + 4*c] = a[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
      m[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = fin ? b[i] : m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] brev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  always_comb rnd_next_state = aes_round(rnd_state, rnd_key, rnd_final);
  always_comb sw_word_in = {sbox(sw_word_out[31:24]), sbox(sw_word_out[23:16]),
                            sbox(sw_word_out[15:8]),  sbox(sw_word_out[7:0])};

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_out_valid", 128'(out_valid), 128'd0);
        else                chk("latency", 128'(cyc - acc_cyc), 128'd11);
      end
      if (out_valid && out_ready && !abort) begin
        if (sb.size() == 0) chk("unexpected_out", 128'd1, 128'd0);
        else                chk("ciphertext", out_ciphertext, sb.pop_front());
      end
    end
    ov_prev = out_valid && !reset;
  end

  // Offer one block; returns #1 after the accepting edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    bit done = 1'b0;
    in_plaintext = pt;
    in_key       = key;
    in_valid     = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !abort && !reset) begin
        sb.push_back(exp);
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 128'(sb.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic quiet_window(input string tag);
    int hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk(tag, 128'(hits), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
    chk({tag, "_busy"},      128'(busy),      128'd0);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_round_idx"}, 128'(round_idx), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_plaintext = '0; in_key = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk_idle("rst");
    chk("rst_ct",    out_ciphertext, 128'd0);
    chk("rst_state", rnd_state,      128'd0);
    @(posedge clk); #1;

    // FIPS-197 C.1
    send(C1_PT, C1_KEY, C1_CT);
    drain();

    // FIPS-197 B with round trace and final round key
    send(brev(128'h3243f6a8885a308d313198a2e0370734),
         brev(128'h2b7e151628aed2a6abf7158809cf4f3c),
         brev(128'h3925841d02dc09fbdc118597196a0b32));
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      chk("b_round_idx", 128'(round_idx), 128'(r));
      chk("b_busy",      128'(busy),      128'd1);
      chk("b_final",     128'(rnd_final), 128'(r == 10));
      if (r == 10) chk("b_rk10", rnd_key, brev(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    end
    @(posedge clk); #1;
    drain();

    // Backpressure, then same-cycle back-to-back accept
    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bp_out_valid_seen", 128'(seen), 128'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_ct",   out_ciphertext,  C1_CT);
      chk("bp_in_ready",  128'(in_ready),  128'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_plaintext = C1_PT; in_key = C1_KEY;
    @(negedge clk);
    chk("b2b_out_valid", 128'(out_valid), 128'd1);
    chk("b2b_in_ready",  128'(in_ready),  128'd1);
    sb.push_back(C1_CT);
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy",  128'(busy),      128'd1);
    chk("b2b_round", 128'(round_idx), 128'd1);
    @(posedge clk); #1;
    drain();

    // Abort at round 4
    send(C1_PT, C1_KEY, C1_CT);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_at_round", 128'(round_idx), 128'd4);
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_idle("abort");
    @(posedge clk); #1;
    quiet_window("abort_no_out");

    // Abort in IDLE blocks acceptance
    in_valid = 1'b1; abort = 1'b1; in_plaintext = C1_PT; in_key = C1_KEY;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_no_accept", 128'(busy), 128'd0);
    @(posedge clk); #1;
    send(C1_PT, C1_KEY, C1_CT);
    drain();

    // Reset at round 7
    send(C1_PT, C1_KEY, C1_CT);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst_ct",    out_ciphertext, 128'd0);
    chk("midrst_state", rnd_state,      128'd0);
    @(posedge clk); #1;
    quiet_window("midrst_no_out");
    send(C1_PT, C1_KEY, C1_CT);
    drain();

    // Input toggling and in_valid pulses while busy
    send(C1_PT, C1_KEY, C1_CT);
    for (int i = 0; i < 8; i++) begin
      in_plaintext = {$urandom, $urandom, $urandom, $urandom};
      in_key       = {$urandom, $urandom, $urandom, $urandom};
      in_valid     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("busy_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
